// File: rtl/riscv_fetch_stage.sv
// rtl/riscv_fetch_stage.sv - IF stage: PC register, next-PC selection and IF/ID pipeline register
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   stall_f, stall_d, flush_d  hazard unit controls for the PC and the IF/ID register
//   redirect_valid/_pc         taken branch/jump target from EX
//   trap_valid/trap_pc         trap entry (mtvec) from the CSR/trap logic
//   imem_addr, imem_rd         combinational instruction-memory interface
//   pc_f                       current fetch PC
//   instr_d, pc_d, pc_plus4_d  IF/ID payload
//   valid_d, misaligned_d      IF/ID status flags

module riscv_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_f,
   input  logic        stall_d,
   input  logic        flush_d,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        trap_valid,
   input  logic [31:0] trap_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rd,
   output logic [31:0] pc_f,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc_plus4_d,
   output logic        valid_d,
   output logic        misaligned_d
);

   logic [31:0] pc_plus4_f;
   logic        misaligned_f;
   logic        kill_d;

   assign imem_addr    = pc_f;
   assign pc_plus4_f   = pc_f + 32'd4;
   assign misaligned_f = (pc_f[1:0] != 2'b00);
   // Any change of control flow squashes the instruction fetched on the wrong path.
   assign kill_d       = trap_valid | redirect_valid | flush_d;

   // Trap beats redirect, and both beat stall_f so a redirect is never dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_f <= RESET_PC;
      end else if (trap_valid) begin
         pc_f <= trap_pc;
      end else if (redirect_valid) begin
         pc_f <= redirect_pc;
      end else if (!stall_f) begin
         pc_f <= pc_plus4_f;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_d      <= NOP_INSTR;
         pc_d         <= 32'd0;
         pc_plus4_d   <= 32'd0;
         valid_d      <= 1'b0;
         misaligned_d <= 1'b0;
      end else if (kill_d) begin
         // pc_d/pc_plus4_d are left alone; only the bubble flags matter.
         instr_d      <= NOP_INSTR;
         valid_d      <= 1'b0;
         misaligned_d <= 1'b0;
      end else if (!stall_d) begin
         // A misaligned fetch still occupies a valid slot so decode can raise the
         // exception; the memory word at that address is meaningless and dropped.
         instr_d      <= misaligned_f ? NOP_INSTR : imem_rd;
         pc_d         <= pc_f;
         pc_plus4_d   <= pc_plus4_f;
         valid_d      <= 1'b1;
         misaligned_d <= misaligned_f;
      end
   end

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// tb/tb_riscv_fetch_stage.sv - directed plus randomized bench for riscv_fetch_stage

module tb_riscv_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_f, stall_d, flush_d;
   logic        redirect_valid, trap_valid;
   logic [31:0] redirect_pc, trap_pc;
   logic [31:0] imem_addr, imem_rd;
   logic [31:0] pc_f, instr_d, pc_d, pc_plus4_d;
   logic        valid_d, misaligned_d;

   logic [31:0] mem [0:255];

   int n_assert = 0;
   int n_fail   = 0;

   // reference state
   logic [31:0] m_pc, m_instr, m_pcd, m_pc4d;
   logic        m_valid, m_mis;
   logic [31:0] x_pc, x_instr, x_pcd, x_pc4d;
   logic        x_valid, x_mis;

   riscv_fetch_stage dut (
      .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .trap_valid(trap_valid), .trap_pc(trap_pc),
      .imem_addr(imem_addr), .imem_rd(imem_rd), .pc_f(pc_f), .instr_d(instr_d),
      .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .misaligned_d(misaligned_d)
   );

   always #5 clk = ~clk;

   assign imem_rd = mem[imem_addr[9:2]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'd0; m_instr = NOP; m_pcd = 32'd0; m_pc4d = 32'd0;
      m_valid = 1'b0; m_mis = 1'b0;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".pc_f"},       pc_f,         m_pc);
      chk({tag, ".imem_addr"},  imem_addr,    m_pc);
      chk({tag, ".instr_d"},    instr_d,      m_instr);
      chk({tag, ".pc_d"},       pc_d,         m_pcd);
      chk({tag, ".pc_plus4_d"}, pc_plus4_d,   m_pc4d);
      chk({tag, ".valid_d"},    {31'd0, valid_d},      {31'd0, m_valid});
      chk({tag, ".misaligned"}, {31'd0, misaligned_d}, {31'd0, m_mis});
   endtask

   // One clock: predict from the rules, let the edge happen, then compare.
   task automatic tick(input string tag);
      logic misal;
      misal = (m_pc % 4) != 0;
      x_pc = trap_valid ? trap_pc : redirect_valid ? redirect_pc : stall_f ? m_pc : m_pc + 32'd4;
      x_instr = m_instr; x_pcd = m_pcd; x_pc4d = m_pc4d; x_valid = m_valid; x_mis = m_mis;
      if (trap_valid || redirect_valid || flush_d) begin
         x_instr = NOP; x_valid = 1'b0; x_mis = 1'b0;
      end else if (!stall_d) begin
         x_instr = misal ? NOP : mem[(m_pc / 4) % 256];
         x_pcd   = m_pc;
         x_pc4d  = m_pc + 32'd4;
         x_valid = 1'b1;
         x_mis   = misal;
      end
      @(posedge clk); #1;
      m_pc = x_pc; m_instr = x_instr; m_pcd = x_pcd; m_pc4d = x_pc4d;
      m_valid = x_valid; m_mis = x_mis;
      chk_model(tag);
   endtask

   task automatic idle_inputs();
      stall_f = 0; stall_d = 0; flush_d = 0;
      redirect_valid = 0; redirect_pc = 0; trap_valid = 0; trap_pc = 0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[0] = 32'h0140_0093;
      mem[1] = 32'h3050_9073;
      mem[2] = 32'h00F0_0113;
      mem[3] = 32'hFFFF_FFFF;
      idle_inputs();
      model_reset();

      // reset state
      reset = 1'b1;
      #2;
      chk("rst.imem_addr", imem_addr, 32'h0);
      chk_model("rst");
      @(negedge clk);
      reset = 1'b0;

      // run three instructions
      tick("run1");
      tick("run2");
      chk("run2.instr_d", instr_d, 32'h3050_9073);
      chk("run2.pc_f", pc_f, 32'h8);
      // stall both stages for two cycles at pc_f=0x8
      @(negedge clk);
      stall_f = 1; stall_d = 1;
      tick("stall1");
      tick("stall2");
      chk("stall.pc_f", pc_f, 32'h8);
      chk("stall.instr_d", instr_d, 32'h3050_9073);
      chk("stall.pc_d", pc_d, 32'h4);
      @(negedge clk);
      stall_f = 0; stall_d = 0;
      tick("resume");
      chk("resume.pc_f", pc_f, 32'hC);
      chk("resume.pc_d", pc_d, 32'h8);
      chk("resume.instr_d", instr_d, 32'h00F0_0113);
      chk("resume.pc_plus4_d", pc_plus4_d, 32'hC);
      tick("illegal");
      chk("illegal.instr_d", instr_d, 32'hFFFF_FFFF);
      chk("illegal.pc_f", pc_f, 32'h10);

      // trap over stall_f
      @(negedge clk);
      stall_f = 1; trap_valid = 1; trap_pc = 32'h14;
      tick("trap");
      chk("trap.pc_f", pc_f, 32'h14);
      chk("trap.instr_d", instr_d, NOP);
      chk("trap.valid_d", {31'd0, valid_d}, 32'd0);
      @(negedge clk);
      idle_inputs();
      tick("trap_next");
      chk("trap_next.pc_d", pc_d, 32'h14);
      chk("trap_next.valid_d", {31'd0, valid_d}, 32'd1);

      // trap beats redirect
      @(negedge clk);
      trap_valid = 1; trap_pc = 32'h14; redirect_valid = 1; redirect_pc = 32'h40;
      tick("trap_vs_redir");
      chk("trap_vs_redir.pc_f", pc_f, 32'h14);

      // misaligned redirect target
      @(negedge clk);
      idle_inputs();
      redirect_valid = 1; redirect_pc = 32'h22;
      tick("misal_redir");
      @(negedge clk);
      idle_inputs();
      tick("misal_cap");
      chk("misal.misaligned_d", {31'd0, misaligned_d}, 32'd1);
      chk("misal.pc_d", pc_d, 32'h22);
      chk("misal.instr_d", instr_d, NOP);
      chk("misal.valid_d", {31'd0, valid_d}, 32'd1);
      chk("misal.pc_f", pc_f, 32'h26);

      // PC wrap
      @(negedge clk);
      redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
      tick("wrap_redir");
      @(negedge clk);
      idle_inputs();
      tick("wrap");
      chk("wrap.pc_f", pc_f, 32'h0);
      chk("wrap.pc_plus4_d", pc_plus4_d, 32'h0);
      chk("wrap.pc_d", pc_d, 32'hFFFF_FFFC);

      // flush beats stall_d
      @(negedge clk);
      flush_d = 1; stall_d = 1;
      tick("flush_stall");
      chk("flush_stall.valid_d", {31'd0, valid_d}, 32'd0);
      @(negedge clk);
      idle_inputs();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         stall_f        = ($urandom_range(0, 3) == 0);
         stall_d        = ($urandom_range(0, 3) == 0);
         flush_d        = ($urandom_range(0, 7) == 0);
         redirect_valid = ($urandom_range(0, 7) == 0);
         trap_valid     = ($urandom_range(0, 15) == 0);
         redirect_pc    = $urandom & (($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         trap_pc        = $urandom & 32'hFFFF_FFFC;
         tick("rand");
         @(negedge clk);
      end
      idle_inputs();
      tick("pre_reset");

      // asynchronous reset mid-cycle
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      chk_model("async_rst");
      @(negedge clk);
      reset = 1'b0;
      tick("post_rst1");
      chk("post_rst1.pc_d", pc_d, 32'h0);
      tick("post_rst2");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
